// File: rtl/hansen_core_rv32i.sv
// hansen_core_rv32i
// Single-cycle RV32I integer core, top-level CPU of the Hansen SoC.
// Each rising edge of clk retires one instruction. The instruction is fetched
// and decoded combinationally from imem_rdata. Register and PC updates land on
// the next rising edge.
//
// Parameters
//   RESET_PC      PC value loaded while reset is high
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-high reset (priority over execution)
//   imem_addr     byte address of the current instruction (= PC)
//   imem_rdata    instruction word, valid combinationally in the same cycle
//   dmem_addr     byte address for LW/SW (rs1 + imm)
//   dmem_wdata    store data (rs2)
//   dmem_we       write strobe, high only during a committing SW cycle
//   dmem_rdata    load data, valid combinationally in the same cycle
//   reg_x1_debug  live value of architectural register x1
//   trap          sticky illegal-instruction flag, cleared only by reset
//
// Build option
//   HANSEN_MUL_EN defined   : adds MUL (funct7=0000001, funct3=000), low 32 bits
//   HANSEN_MUL_EN undefined : every funct7=0000001 OP encoding is illegal
module hansen_core_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] reg_x1_debug,
    output logic        trap
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef HANSEN_MUL_EN
    localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic        trap_q, trap_d;
    // Entry 0 is cleared on reset and never written, so x0 always reads 0
    logic [31:0] regs_q [0:31];

    // Instruction fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    assign instr  = imem_rdata;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Sign-extended immediates for each RV32I format
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Register reads are combinational with no bypass from the pending write
    logic [31:0]        rs1_val, rs2_val;
    logic signed [31:0] rs1_s, rs2_s, imm_i_s;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign rs1_s   = rs1_val;
    assign rs2_s   = rs2_val;
    assign imm_i_s = imm_i;

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    // Decode / execute results before the trap gate is applied
    logic        illegal;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic [31:0] pc_next;
    logic        mem_store;
    logic        take_branch;

    always_comb begin
        illegal     = 1'b0;
        rd_we       = 1'b0;
        rd_wdata    = 32'd0;
        pc_next     = pc_plus4;
        mem_store   = 1'b0;
        take_branch = 1'b0;

        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_next  = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    illegal = 1'b1;
                end else begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_next  = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  take_branch = (rs1_val == rs2_val);
                    3'b001:  take_branch = (rs1_val != rs2_val);
                    3'b100:  take_branch = (rs1_s < rs2_s);
                    3'b101:  take_branch = (rs1_s >= rs2_s);
                    3'b110:  take_branch = (rs1_val < rs2_val);
                    3'b111:  take_branch = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
                if (take_branch) begin
                    pc_next = pc_q + imm_b;
                end
            end
            OPC_LOAD: begin
                // Only word loads exist; byte/half widths are illegal
                if (funct3 == 3'b010) begin
                    rd_we    = 1'b1;
                    rd_wdata = dmem_rdata;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    mem_store = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000: rd_wdata = rs1_val + imm_i;
                    3'b010: rd_wdata = {31'd0, (rs1_s < imm_i_s)};
                    3'b011: rd_wdata = {31'd0, (rs1_val < imm_i)};
                    3'b100: rd_wdata = rs1_val ^ imm_i;
                    3'b110: rd_wdata = rs1_val | imm_i;
                    3'b111: rd_wdata = rs1_val & imm_i;
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            rd_wdata = rs1_val << rs2;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        // funct3 101: shift amount lives in the rs2 field
                        if (funct7 == F7_BASE) begin
                            rd_wdata = rs1_val >> rs2;
                        end else if (funct7 == F7_ALT) begin
                            rd_wdata = rs1_s >>> rs2;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                rd_we = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  rd_wdata = rs1_val + rs2_val;
                        3'b001:  rd_wdata = rs1_val << rs2_val[4:0];
                        3'b010:  rd_wdata = {31'd0, (rs1_s < rs2_s)};
                        3'b011:  rd_wdata = {31'd0, (rs1_val < rs2_val)};
                        3'b100:  rd_wdata = rs1_val ^ rs2_val;
                        3'b101:  rd_wdata = rs1_val >> rs2_val[4:0];
                        3'b110:  rd_wdata = rs1_val | rs2_val;
                        default: rd_wdata = rs1_val & rs2_val;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  rd_wdata = rs1_val - rs2_val;
                        3'b101:  rd_wdata = rs1_s >>> rs2_val[4:0];
                        default: illegal = 1'b1;
                    endcase
`ifdef HANSEN_MUL_EN
                end else if (funct7 == F7_MUL) begin
                    if (funct3 == 3'b000) begin
                        rd_wdata = rs1_val * rs2_val;
                    end else begin
                        illegal = 1'b1;
                    end
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            // FENCE, SYSTEM and every unlisted opcode
            default: illegal = 1'b1;
        endcase
    end

    // Commit gate: once trapped (or on an illegal word) the PC freezes and
    // nothing architectural is written
    logic rf_we;

    always_comb begin
        pc_d   = pc_q;
        trap_d = trap_q;
        rf_we  = 1'b0;
        if (!trap_q) begin
            if (illegal) begin
                trap_d = 1'b1;
            end else begin
                pc_d  = pc_next;
                rf_we = rd_we && (rd != 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            trap_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q   <= pc_d;
            trap_q <= trap_d;
            if (rf_we) begin
                regs_q[rd] <= rd_wdata;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign dmem_addr    = rs1_val + (mem_store ? imm_s : imm_i);
    assign dmem_wdata   = rs2_val;
    assign dmem_we      = mem_store && !trap_q && !reset;
    assign reg_x1_debug = regs_q[1];
    assign trap         = trap_q;

endmodule

// File: tb/tb_hansen_core_rv32i.sv
// tb_hansen_core_rv32i
// Directed-vector bench for hansen_core_rv32i. A small instruction ROM is
// modelled as an array indexed by imem_addr; dmem_rdata is driven directly.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_hansen_core_rv32i;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [31:0] reg_x1_debug;
    logic        trap;

    logic [31:0] prog [0:63];

    int pass_cnt;
    int total_cnt;

    hansen_core_rv32i #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_we     (dmem_we),
        .dmem_rdata  (dmem_rdata),
        .reg_x1_debug(reg_x1_debug),
        .trap        (trap)
    );

    assign imem_rdata = prog[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            prog[i] = NOP;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = 32'h00A0_0093;            // ADDI x1,x0,10
        do_reset();
        step();
        step();
        // Reset held across a cycle where ADDI sits at the PC
        reset = 1'b1;
        step();
        step();
        total_cnt++;
        if (imem_addr !== 32'h0) $display("FAIL reset_pc got=%h want=%h", imem_addr, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (reg_x1_debug !== 32'h0) $display("FAIL reset_x1 got=%h want=%h", reg_x1_debug, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (trap !== 1'b0) $display("FAIL reset_trap got=%b want=0", trap);
        else pass_cnt++;
        total_cnt++;
        if (dmem_we !== 1'b0) $display("FAIL reset_we got=%b want=0", dmem_we);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_nop_run();
        clear_prog();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            total_cnt++;
            if (imem_addr !== 32'(4 * k)) $display("FAIL nop_pc[%0d] got=%h want=%h", k, imem_addr, 32'(4 * k));
            else pass_cnt++;
            total_cnt++;
            if (dmem_we !== 1'b0) $display("FAIL nop_we[%0d] got=%b want=0", k, dmem_we);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (reg_x1_debug !== 32'h0) $display("FAIL nop_x1 got=%h want=0", reg_x1_debug);
        else pass_cnt++;
        total_cnt++;
        if (trap !== 1'b0) $display("FAIL nop_trap got=%b want=0", trap);
        else pass_cnt++;
    endtask

    task automatic test_addi();
        clear_prog();
        prog[0] = 32'h00A0_0093;            // ADDI x1,x0,10
        do_reset();
        for (int k = 0; k < 10; k++) step();
        total_cnt++;
        if (reg_x1_debug !== 32'd10) $display("FAIL addi_x1 got=%h want=%h", reg_x1_debug, 32'd10);
        else pass_cnt++;
    endtask

    // Run prog from reset, checking x1 after each listed instruction retires
    task automatic test_alu();
        logic [31:0] exp_x1 [0:10];
        clear_prog();
        prog[0]  = 32'hFFF0_0093; exp_x1[0]  = 32'hFFFF_FFFF; // ADDI x1,x0,-1
        prog[1]  = 32'h0010_8093; exp_x1[1]  = 32'h0000_0000; // ADDI x1,x1,1 (wrap)
        prog[2]  = 32'h8000_00B7; exp_x1[2]  = 32'h8000_0000; // LUI x1,0x80000
        prog[3]  = 32'hFFF0_8093; exp_x1[3]  = 32'h7FFF_FFFF; // ADDI x1,x1,-1
        prog[4]  = 32'hFF80_0113; exp_x1[4]  = 32'h7FFF_FFFF; // ADDI x2,x0,-8
        prog[5]  = 32'h4011_5093; exp_x1[5]  = 32'hFFFF_FFFC; // SRAI x1,x2,1
        prog[6]  = 32'h01C1_5093; exp_x1[6]  = 32'h0000_000F; // SRLI x1,x2,28
        prog[7]  = 32'h0020_30B3; exp_x1[7]  = 32'h0000_0001; // SLTU x1,x0,x2
        prog[8]  = 32'h0001_20B3; exp_x1[8]  = 32'h0000_0001; // SLT x1,x2,x0
        prog[9]  = 32'h4020_00B3; exp_x1[9]  = 32'h0000_0008; // SUB x1,x0,x2
        prog[10] = 32'h0000_0097; exp_x1[10] = 32'h0000_0028; // AUIPC x1,0 at 0x28
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step();
            total_cnt++;
            if (reg_x1_debug !== exp_x1[k]) $display("FAIL alu_x1[%0d] got=%h want=%h", k, reg_x1_debug, exp_x1[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mem();
        clear_prog();
        prog[0] = 32'h0050_0113;            // ADDI x2,x0,5
        prog[1] = 32'h0420_2023;            // SW x2,0x40(x0)
        prog[2] = 32'h0400_2083;            // LW x1,0x40(x0)
        dmem_rdata = 32'h0;
        do_reset();
        step();
        total_cnt++;
        if (dmem_we !== 1'b1) $display("FAIL sw_we got=%b want=1", dmem_we);
        else pass_cnt++;
        total_cnt++;
        if (dmem_addr !== 32'h40) $display("FAIL sw_addr got=%h want=%h", dmem_addr, 32'h40);
        else pass_cnt++;
        total_cnt++;
        if (dmem_wdata !== 32'd5) $display("FAIL sw_wdata got=%h want=%h", dmem_wdata, 32'd5);
        else pass_cnt++;
        step();
        dmem_rdata = 32'd5;
        total_cnt++;
        if (dmem_we !== 1'b0) $display("FAIL lw_we got=%b want=0", dmem_we);
        else pass_cnt++;
        total_cnt++;
        if (dmem_addr !== 32'h40) $display("FAIL lw_addr got=%h want=%h", dmem_addr, 32'h40);
        else pass_cnt++;
        step();
        dmem_rdata = 32'h0;
        total_cnt++;
        if (reg_x1_debug !== 32'd5) $display("FAIL lw_x1 got=%h want=%h", reg_x1_debug, 32'd5);
        else pass_cnt++;
    endtask

    task automatic test_branch_jump();
        clear_prog();
        prog[0] = 32'h0000_0463;            // BEQ x0,x0,+8
        prog[1] = 32'h0010_0093;            // ADDI x1,x0,1 (must be skipped)
        prog[2] = 32'h00C0_00EF;            // JAL x1,+12
        prog[5] = 32'h0000_1463;            // BNE x0,x0,+8 (not taken)
        prog[6] = 32'h0050_80E7;            // JALR x1,x1,5 -> 16
        do_reset();
        step();
        total_cnt++;
        if (imem_addr !== 32'd8) $display("FAIL beq_pc got=%h want=%h", imem_addr, 32'd8);
        else pass_cnt++;
        step();
        total_cnt++;
        if (imem_addr !== 32'd20) $display("FAIL jal_pc got=%h want=%h", imem_addr, 32'd20);
        else pass_cnt++;
        total_cnt++;
        if (reg_x1_debug !== 32'd12) $display("FAIL jal_x1 got=%h want=%h", reg_x1_debug, 32'd12);
        else pass_cnt++;
        step();
        total_cnt++;
        if (imem_addr !== 32'd24) $display("FAIL bne_pc got=%h want=%h", imem_addr, 32'd24);
        else pass_cnt++;
        step();
        total_cnt++;
        if (imem_addr !== 32'd16) $display("FAIL jalr_pc got=%h want=%h", imem_addr, 32'd16);
        else pass_cnt++;
        total_cnt++;
        if (reg_x1_debug !== 32'd28) $display("FAIL jalr_x1 got=%h want=%h", reg_x1_debug, 32'd28);
        else pass_cnt++;
    endtask

    task automatic test_trap();
        clear_prog();
        prog[0] = 32'h00A0_0093;            // ADDI x1,x0,10
        prog[1] = 32'hFFFF_FFFF;            // illegal
        prog[2] = 32'h0010_0093;            // ADDI x1,x0,1 (never reached)
        do_reset();
        step();
        total_cnt++;
        if (trap !== 1'b0) $display("FAIL trap_early got=%b want=0", trap);
        else pass_cnt++;
        step();
        total_cnt++;
        if (trap !== 1'b1) $display("FAIL trap_set got=%b want=1", trap);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 32'd4) $display("FAIL trap_pc got=%h want=%h", imem_addr, 32'd4);
        else pass_cnt++;
        // Replace the illegal word: the trapped core must still not move
        prog[1] = 32'h0020_0093;            // ADDI x1,x0,2
        step();
        step();
        total_cnt++;
        if (imem_addr !== 32'd4) $display("FAIL trap_hold_pc got=%h want=%h", imem_addr, 32'd4);
        else pass_cnt++;
        total_cnt++;
        if (reg_x1_debug !== 32'd10) $display("FAIL trap_hold_x1 got=%h want=%h", reg_x1_debug, 32'd10);
        else pass_cnt++;
        total_cnt++;
        if (trap !== 1'b1) $display("FAIL trap_sticky got=%b want=1", trap);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (trap !== 1'b0) $display("FAIL trap_clear got=%b want=0", trap);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 32'd0) $display("FAIL trap_clear_pc got=%h want=%h", imem_addr, 32'd0);
        else pass_cnt++;
        // SW following a trap must not strobe memory
        clear_prog();
        prog[0] = 32'h0000_0073;            // ECALL (SYSTEM)
        prog[1] = 32'h0000_2023;            // SW x0,0(x0)
        do_reset();
        step();
        total_cnt++;
        if (trap !== 1'b1) $display("FAIL ecall_trap got=%b want=1", trap);
        else pass_cnt++;
        total_cnt++;
        if (dmem_we !== 1'b0) $display("FAIL ecall_we got=%b want=0", dmem_we);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        clear_prog();
        prog[0] = 32'h0060_0113;            // ADDI x2,x0,6
        prog[1] = 32'h0070_0193;            // ADDI x3,x0,7
        prog[2] = 32'h0231_00B3;            // MUL x1,x2,x3
        do_reset();
        step();
        step();
        step();
`ifdef HANSEN_MUL_EN
        total_cnt++;
        if (reg_x1_debug !== 32'd42) $display("FAIL mul_x1 got=%h want=%h", reg_x1_debug, 32'd42);
        else pass_cnt++;
        total_cnt++;
        if (trap !== 1'b0) $display("FAIL mul_trap got=%b want=0", trap);
        else pass_cnt++;
`else
        total_cnt++;
        if (trap !== 1'b1) $display("FAIL mul_trap got=%b want=1", trap);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 32'd8) $display("FAIL mul_pc got=%h want=%h", imem_addr, 32'd8);
        else pass_cnt++;
        total_cnt++;
        if (reg_x1_debug !== 32'd0) $display("FAIL mul_x1 got=%h want=%h", reg_x1_debug, 32'd0);
        else pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset      = 1'b1;
        dmem_rdata = 32'h0;
        clear_prog();
        test_reset();
        test_nop_run();
        test_addi();
        test_alu();
        test_mem();
        test_branch_jump();
        test_trap();
        test_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
